stream_arb_buf: RTL and testbench



---
 rtl/stream_arb_pkg.sv | 53 +++++
 rtl/stream_fifo.sv | 76 +++++++
 rtl/stream_arb_buf.sv | 98 +++++++++
 tb/tb_stream_arb_buf.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types, width helpers and the round-robin grant function for the
// stream concentrator (stream_arb_buf and its per-channel stream_fifo).
package stream_arb_pkg;

    // Widest request vector the grant function handles
    localparam int unsigned MAX_CH   = 32;
    localparam int unsigned MAX_CH_W = 5;

    // Default configuration
    localparam int unsigned DEF_CH_NUM = 4;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 4;

    // Ceiling log2 for elaboration-time width derivation
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Widths of the default configuration
    localparam int unsigned CH_W  = clog2(DEF_CH_NUM);
    localparam int unsigned PTR_W = clog2(DEF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // One-hot grant: first requester after ptr, searching upward with wrap over n channels
    function automatic logic [MAX_CH-1:0] rr_grant(input logic [MAX_CH-1:0] req,
                                                   input int unsigned       ptr,
                                                   input int unsigned       n);
        logic [MAX_CH-1:0]   gnt;
        logic                found;
        logic [MAX_CH_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= MAX_CH; off++) begin
            if (!found && off <= n) begin
                idx = MAX_CH_W'((ptr + off) % n);
                if (req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Per-channel count-based FIFO with registered ready, flush and head-of-queue peek.
module stream_fifo
    import stream_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    input  logic              flush,
    input  logic              pop,
    output logic              ready,
    output logic              empty_c,
    output logic [DATA_W-1:0] head_c
);

    localparam int unsigned ADDR_BITS = clog2(DEPTH);
    localparam int unsigned CNT_BITS  = ADDR_BITS + 1;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0]  count;
    logic [CNT_BITS-1:0]  cnt_nxt_c;
    logic                 push_c;
    logic                 pop_ok_c;

    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];

    // Qualified push/pop and next occupancy; flush wins over both
    always_comb begin
        push_c    = push_valid && ready && !flush;
        pop_ok_c  = pop && !flush && !empty_c;
        cnt_nxt_c = count;
        if (flush) begin
            cnt_nxt_c = '0;
        end else begin
            cnt_nxt_c = count + CNT_BITS'(push_c) - CNT_BITS'(pop_ok_c);
        end
    end

    // Pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            count <= cnt_nxt_c;
            ready <= (cnt_nxt_c != CNT_BITS'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_c) begin
                    wr_ptr <= wr_ptr + ADDR_BITS'(1);
                end
                if (pop_ok_c) begin
                    rd_ptr <= rd_ptr + ADDR_BITS'(1);
                end
            end
        end
    end

    // Storage array; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/stream_arb_buf.sv
// N-channel stream concentrator: per-channel FIFOs drained round-robin into one
// registered output stream with backpressure. Optional feature macro:
// STREAM_ARB_CHID_EN adds the dout_chid source-channel output register.
module stream_arb_buf
    import stream_arb_pkg::*;
#(
    parameter int unsigned CH_NUM = DEF_CH_NUM,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH_NUM-1:0]          din_valid,
    input  logic [CH_NUM*DATA_W-1:0]   din,
    output logic [CH_NUM-1:0]          din_ready,
    input  logic [CH_NUM-1:0]          flush,
    output logic                       dout_valid,
    output logic [DATA_W-1:0]          dout,
`ifdef STREAM_ARB_CHID_EN
    output logic [clog2(CH_NUM)-1:0]   dout_chid,
`endif
    input  logic                       dout_ready
);

    localparam int unsigned SEL_W = clog2(CH_NUM);

    logic [CH_NUM-1:0] empty_c;
    logic [CH_NUM-1:0] req_c;
    logic [CH_NUM-1:0] gnt_c;
    logic [CH_NUM-1:0] pop_c;
    logic [DATA_W-1:0] head_c [CH_NUM];
    logic [SEL_W-1:0]  gnt_idx_c;
    logic [SEL_W-1:0]  rr_ptr;
    logic              load_en_c;
    logic              any_gnt_c;

    // One FIFO per input channel
    for (genvar i = 0; i < int'(CH_NUM); i++) begin : g_ch
        stream_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_valid (din_valid[i]),
            .push_data  (din[i*DATA_W +: DATA_W]),
            .flush      (flush[i]),
            .pop        (pop_c[i]),
            .ready      (din_ready[i]),
            .empty_c    (empty_c[i]),
            .head_c     (head_c[i])
        );
    end

    // Arbitration over non-empty, non-flushed channels; pop only when the output loads
    always_comb begin
        load_en_c = !dout_valid || dout_ready;
        req_c     = ~empty_c & ~flush;
        gnt_c     = CH_NUM'(rr_grant(MAX_CH'(req_c), 32'(rr_ptr), CH_NUM));
        any_gnt_c = |gnt_c;
        gnt_idx_c = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (gnt_c[i]) begin
                gnt_idx_c = SEL_W'(i);
            end
        end
        pop_c = load_en_c ? gnt_c : '0;
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            rr_ptr     <= SEL_W'(CH_NUM - 1);
        end else if (load_en_c) begin
            if (any_gnt_c) begin
                dout_valid <= 1'b1;
                dout       <= head_c[gnt_idx_c];
                rr_ptr     <= gnt_idx_c;
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_ARB_CHID_EN
    // Source channel travels with the data word
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_chid <= '0;
        end else if (load_en_c && any_gnt_c) begin
            dout_chid <= gnt_idx_c;
        end
    end
`endif

endmodule

// File: tb/tb_stream_arb_buf.sv
// Self-checking bench for stream_arb_buf: directed scenarios plus randomized
// traffic compared every cycle against a queue-level reference model.
module tb_stream_arb_buf;

    localparam int CH  = 4;
    localparam int DW  = 8;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] din_valid;
    logic [CH*DW-1:0] din;
    logic [CH-1:0] din_ready;
    logic [CH-1:0] flush;
    logic          dout_valid;
    logic [DW-1:0] dout;
    logic          dout_ready;
`ifdef STREAM_ARB_CHID_EN
    logic [1:0]    dout_chid;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: per-channel ordered word lists and output slot
    logic [DW-1:0] mq [CH][DEP];
    int            mcnt [CH];
    logic [CH-1:0] mready;
    logic          mvalid;
    logic [DW-1:0] mdout;
    logic [1:0]    mchid;
    int            mptr;

    always #5 clk = ~clk;

    stream_arb_buf #(
        .CH_NUM (CH),
        .DATA_W (DW),
        .DEPTH  (DEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .flush      (flush),
        .dout_valid (dout_valid),
        .dout       (dout),
`ifdef STREAM_ARB_CHID_EN
        .dout_chid  (dout_chid),
`endif
        .dout_ready (dout_ready)
    );

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int g;
        int c;
        logic acc;
        if (rst) begin
            for (int i = 0; i < CH; i++) mcnt[i] = 0;
            mready = '0;
            mvalid = 1'b0;
            mdout  = '0;
            mchid  = '0;
            mptr   = CH - 1;
        end else begin
            if (!mvalid || dout_ready) begin
                g = -1;
                for (int k = 1; k <= CH; k++) begin
                    c = (mptr + k) % CH;
                    if (g < 0 && mcnt[c] > 0 && !flush[c]) g = c;
                end
                if (g >= 0) begin
                    mvalid = 1'b1;
                    mdout  = mq[g][0];
                    mchid  = 2'(g);
                    mptr   = g;
                    for (int j = 0; j < DEP - 1; j++) mq[g][j] = mq[g][j+1];
                    mcnt[g] = mcnt[g] - 1;
                end else begin
                    mvalid = 1'b0;
                end
            end
            for (int i = 0; i < CH; i++) begin
                acc = din_valid[i] && mready[i] && !flush[i];
                if (flush[i]) mcnt[i] = 0;
                if (acc) begin
                    mq[i][mcnt[i]] = din[i*DW +: DW];
                    mcnt[i] = mcnt[i] + 1;
                end
                mready[i] = (mcnt[i] != DEP);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; din_valid = '0; flush = '0; dout_ready = 1'b0; din = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; din_valid = 4'hF; din = $urandom; flush = '0; dout_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (din_ready !== 4'h0) begin
                tests_failed++; $display("FAIL reset_din_ready cyc%0d got %h want 0", c, din_ready);
            end
            tests_run++;
            if (dout_valid !== 1'b0) begin
                tests_failed++; $display("FAIL reset_dout_valid cyc%0d got %b want 0", c, dout_valid);
            end
        end
        rst = 1'b0; din_valid = '0;
        tick();
        tests_run++;
        if (din_ready !== 4'hF) begin
            tests_failed++; $display("FAIL reset_release_ready got %h want f", din_ready);
        end
        tests_run++;
        if (dout !== 8'h00) begin
            tests_failed++; $display("FAIL reset_dout got %h want 00", dout);
        end
`ifdef STREAM_ARB_CHID_EN
        tests_run++;
        if (dout_chid !== 2'd0) begin
            tests_failed++; $display("FAIL reset_chid got %0d want 0", dout_chid);
        end
`endif
        dout_ready = 1'b1;
        tick();
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_nothing_stored dout_valid got %b want 0", dout_valid);
        end
    endtask

    task automatic test_latency();
        do_reset();
        dout_ready = 1'b1;
        din_valid  = 4'b0100;
        din        = '0;
        din[2*DW +: DW] = 8'hA5;
        tick();
        din_valid = '0;
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++; $display("FAIL latency_no_bypass dout_valid got %b want 0", dout_valid);
        end
        tick();
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
            tests_failed++; $display("FAIL latency_out got v=%b d=%h want v=1 d=a5", dout_valid, dout);
        end
`ifdef STREAM_ARB_CHID_EN
        tests_run++;
        if (dout_chid !== 2'd2) begin
            tests_failed++; $display("FAIL latency_chid got %0d want 2", dout_chid);
        end
`endif
        tick();
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++; $display("FAIL latency_drop dout_valid got %b want 0", dout_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] sent [CH][DEP];
        logic [DW-1:0] exp_d;
        do_reset();
        dout_ready = 1'b0;
        for (int w = 0; w < DEP; w++) begin
            din_valid = 4'hF;
            for (int i = 0; i < CH; i++) begin
                sent[i][w] = 8'($urandom);
                din[i*DW +: DW] = sent[i][w];
            end
            tick();
        end
        din_valid  = '0;
        dout_ready = 1'b1;
        for (int j = 0; j < CH * DEP; j++) begin
            exp_d = sent[j % CH][j / CH];
            tests_run++;
            if (dout_valid !== 1'b1 || dout !== exp_d) begin
                tests_failed++;
                $display("FAIL rr_word%0d got v=%b d=%h want v=1 d=%h", j, dout_valid, dout, exp_d);
            end
`ifdef STREAM_ARB_CHID_EN
            tests_run++;
            if (dout_chid !== 2'(j % CH)) begin
                tests_failed++; $display("FAIL rr_chid%0d got %0d want %0d", j, dout_chid, j % CH);
            end
`endif
            tick();
        end
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rr_empty_after dout_valid got %b want 0", dout_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] words [6];
        int nacc;
        do_reset();
        for (int w = 0; w < 6; w++) words[w] = 8'($urandom);
        nacc = 0;
        dout_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            din_valid = (nacc < 6) ? 4'b0010 : 4'b0000;
            din = '0;
            if (nacc < 6) din[1*DW +: DW] = words[nacc];
            if (din_valid[1] && din_ready[1]) begin
                tick();
                nacc++;
            end else begin
                tick();
            end
            if (c >= 1) begin
                tests_run++;
                if (dout_valid !== 1'b1 || dout !== words[0]) begin
                    tests_failed++;
                    $display("FAIL bp_hold cyc%0d got v=%b d=%h want v=1 d=%h", c, dout_valid, dout, words[0]);
                end
            end
        end
        din_valid = '0;
        tests_run++;
        if (nacc !== 5) begin
            tests_failed++; $display("FAIL bp_accepted got %0d want 5", nacc);
        end
        tests_run++;
        if (din_ready[1] !== 1'b0) begin
            tests_failed++; $display("FAIL bp_ready got %b want 0", din_ready[1]);
        end
        dout_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            tests_run++;
            if (dout_valid !== 1'b1 || dout !== words[w]) begin
                tests_failed++;
                $display("FAIL bp_drain%0d got v=%b d=%h want v=1 d=%h", w, dout_valid, dout, words[w]);
            end
            tick();
        end
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_drain_end dout_valid got %b want 0", dout_valid);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] words [4];
        do_reset();
        for (int w = 0; w < 4; w++) words[w] = 8'($urandom);
        dout_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            din_valid = 4'b1000;
            din = '0;
            din[3*DW +: DW] = words[w];
            tick();
        end
        din[3*DW +: DW] = words[3];
        flush = 4'b1000;
        tick();
        flush = '0; din_valid = '0;
        tests_run++;
        if (din_ready[3] !== 1'b1) begin
            tests_failed++; $display("FAIL flush_ready got %b want 1", din_ready[3]);
        end
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== words[0]) begin
            tests_failed++; $display("FAIL flush_keep_out got v=%b d=%h want v=1 d=%h", dout_valid, dout, words[0]);
        end
        dout_ready = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (dout_valid !== 1'b0) begin
                tests_failed++; $display("FAIL flush_dropped cyc%0d got v=%b d=%h want v=0", c, dout_valid, dout);
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        int loads;
        bit found;
        do_reset();
        dout_ready = 1'b1;
        din = '0;
        for (int c = 0; c < 6; c++) begin
            din_valid = 4'b0001;
            din[0 +: DW] = 8'($urandom_range(0, 127));
            tick();
        end
        din_valid = 4'b0101;
        din[2*DW +: DW] = 8'hC2;
        din[0 +: DW] = 8'($urandom_range(0, 127));
        tests_run++;
        if (din_ready[2] !== 1'b1) begin
            tests_failed++; $display("FAIL starve_ch2_ready got %b want 1", din_ready[2]);
        end
        tick();
        loads = 0;
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            din_valid = 4'b0001;
            din[0 +: DW] = 8'($urandom_range(0, 127));
            tick();
            if (dout_valid) begin
                loads++;
                if (dout == 8'hC2) found = 1'b1;
            end
        end
        din_valid = '0;
        tests_run++;
        if (!found || loads > CH) begin
            tests_failed++; $display("FAIL starve_grant found=%0d loads=%0d want found within %0d", found, loads, CH);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dout_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            din_valid = 4'($urandom);
            din = $urandom;
            tick();
        end
        din_valid = '0;
        dout_ready = 1'b1;
        rst = 1'b1;
        tick();
        tests_run++;
        if (dout_valid !== 1'b0 || din_ready !== 4'h0) begin
            tests_failed++; $display("FAIL midrst got v=%b rdy=%h want v=0 rdy=0", dout_valid, din_ready);
        end
        rst = 1'b0;
        tick(); tick();
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_discard dout_valid got %b want 0", dout_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst        = (c == 200);
            din_valid  = 4'($urandom);
            din        = $urandom;
            dout_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < CH; i++) flush[i] = ($urandom_range(0, 15) == 0);
            tick();
            tests_run++;
            if (din_ready !== mready) begin
                tests_failed++; $display("FAIL rand_ready cyc%0d got %h want %h", c, din_ready, mready);
            end
            tests_run++;
            if (dout_valid !== mvalid || dout !== mdout) begin
                tests_failed++;
                $display("FAIL rand_out cyc%0d got v=%b d=%h want v=%b d=%h", c, dout_valid, dout, mvalid, mdout);
            end
`ifdef STREAM_ARB_CHID_EN
            tests_run++;
            if (dout_chid !== mchid) begin
                tests_failed++; $display("FAIL rand_chid cyc%0d got %0d want %0d", c, dout_chid, mchid);
            end
`endif
        end
        rst = 1'b0; flush = '0; din_valid = '0;
    endtask

    initial begin
        rst = 1'b1; din_valid = '0; din = '0; flush = '0; dout_ready = 1'b0;
        mready = '0; mvalid = 1'b0; mdout = '0; mchid = '0; mptr = CH - 1;
        for (int i = 0; i < CH; i++) mcnt[i] = 0;
        test_reset();
        test_latency();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
